clkmon: RTL and testbench
=========================

# clkmon

Clock-consumer monitor that sits at the receiving end of the `clkdiv` output. It samples the divided clock (`SLOW_IN`) in the `CLK_IN` domain and measures each full period in `CLK_IN` cycles. It declares lock once consecutive periods match the expected value, and flags loss of the slow clock. Board-level logic uses it to gate anything that depends on the divided clock being alive and on-frequency.

## Interface
- `EXP_PERIOD`, default 200: expected `SLOW_IN` period in `CLK_IN` cycles (divider toggles every 100 cycles).
- `TOL`, default 2: allowed absolute deviation from `EXP_PERIOD`, inclusive.
- `LOCK_CNT`, default 4: consecutive in-tolerance periods required to assert `LOCKED`.
- `TIMEOUT`, default 1000: cycles without a rising edge before loss is declared; must be > `EXP_PERIOD`+`TOL`.
- `CLK_IN`  in  1  system clock; all logic on its rising edge.
- `clr`  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `SLOW_IN`  in  1  divided clock under test; treated as asynchronous to `CLK_IN`.
- `PERIOD`  out  32  last measured period in `CLK_IN` cycles.
- `period_valid`  out  1  one-cycle pulse when `PERIOD` is updated.
- `LOCKED`  out  1  frequency lock indicator.
- `TIMEOUT_FLAG`  out  1  slow clock lost; cleared on next detected rising edge.
- `ERR_CNT`  out  8  saturating count of out-of-tolerance periods since reset.

## Operation
- Input path: 2-flop synchronizer `s1`, `s2`, then history flop `s3`.
  - `rise` = `s2` & ~`s3`.
  - No other path samples `SLOW_IN`.
- Counter `cnt` (32 bit):
  - On `rise`: `cnt` <= 1.
  - Otherwise: `cnt` increments, saturating at `TIMEOUT`.
- States:
  - **IDLE**: after reset or timeout; waits for the first `rise`. No measurement is produced.
  - **MEAS**: counting. Each `rise` closes a period.
  - **LOCK**: same as MEAS with `LOCKED`=1.
- Transitions:
  - IDLE --rise--> MEAS. `cnt` <= 1, `TIMEOUT_FLAG` <= 0. No `period_valid`.
  - MEAS/LOCK --rise--> `PERIOD` <= `cnt`, `period_valid` <= 1.
    - In-tolerance means |`cnt` − `EXP_PERIOD`| <= `TOL`, computed unsigned with no wrap.
    - In tolerance: `match` increments, saturating at `LOCK_CNT`. When `match` reaches `LOCK_CNT`, go to LOCK.
    - Out of tolerance: `match` <= 0, go to MEAS (leaving LOCK), `ERR_CNT` increments, saturating at 255.
  - MEAS/LOCK with `cnt` == `TIMEOUT` and no `rise`: go to IDLE.
    - `TIMEOUT_FLAG` <= 1, `match` <= 0, `LOCKED` <= 0.
    - `PERIOD` holds its last value.
    - `ERR_CNT` increments once per timeout event.
- A `rise` in the same cycle `cnt` hits `TIMEOUT` counts as a rise: the period equals `TIMEOUT`, out of tolerance.
- Reset values:
  - `PERIOD`=0, `period_valid`=0, `LOCKED`=0, `TIMEOUT_FLAG`=0, `ERR_CNT`=0.
  - State IDLE, `cnt`=0, `match`=0, `s1`/`s2`/`s3`=0.
- Reset asserted mid-measurement: every register returns to its reset value immediately; no partial period is reported after release.

## Timing
- Latency from `SLOW_IN` rising (sampled at edge k) to `rise`: `s1`@k, `s2`@k+1, `rise` true in cycle k+1 and acted on at edge k+2.
  - `PERIOD`/`period_valid` are visible after edge k+2.
- `period_valid` is high for exactly one cycle per measured period. It is never asserted for the first rise after IDLE.
- `LOCKED` rises in the same cycle as the `period_valid` of the `LOCK_CNT`-th consecutive good period. It falls in the same cycle as the `period_valid` of a bad period, or the cycle after `cnt` reaches `TIMEOUT`.
- All outputs are registered; there are no combinational paths from `SLOW_IN`.

## Test plan
- Nominal: drive `SLOW_IN` from `clkdiv` (200-cycle period) after reset release.
  - First rise produces no pulse.
  - Each subsequent rise gives `PERIOD`=200 and `period_valid` pulses.
  - `LOCKED`=1 at the 4th `period_valid`; `ERR_CNT`=0.
- Tolerance edges: periods of 198, 202, 203.
  - 198 and 202 count toward lock.
  - 203 clears `LOCKED` and `match`, and sets `ERR_CNT`=1.
  - Four further 200-cycle periods re-lock.
- Loss: locked, then hold `SLOW_IN` low.
  - Exactly `TIMEOUT`=1000 cycles after the last rise: `TIMEOUT_FLAG`=1, `LOCKED`=0, `PERIOD` unchanged (200).
  - Restart `SLOW_IN`: the first rise clears `TIMEOUT_FLAG` with no `period_valid`.
- Reset mid-operation: assert `clr`=0 mid-period while locked.
  - All outputs are 0 asynchronously.
  - After release, the first `period_valid` comes only on the second rise.
- Glitch/async: `SLOW_IN` edges jittered ±1 `CLK_IN` phase with a 100-cycle half period.
  - All `PERIOD` values in 199..201.
  - `LOCKED` stays 1 once acquired.
- `ERR_CNT` saturation: 300 periods of 150 cycles → `ERR_CNT`=255, `LOCKED` never asserted.

Source files
------------

// File: rtl/clkmon.sv
// clkmon: measures SLOW_IN periods in CLK_IN cycles,
// tracks frequency lock and flags loss of the slow clock.
module clkmon #(
  parameter int unsigned EXP_PERIOD = 200,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic        CLK_IN,
  input  logic        clr,
  input  logic        SLOW_IN,
  output logic [31:0] PERIOD,
  output logic        period_valid,
  output logic        LOCKED,
  output logic        TIMEOUT_FLAG,
  output logic [7:0]  ERR_CNT
);

  localparam logic [31:0] EXP = 32'(EXP_PERIOD);
  localparam logic [31:0] TLV = 32'(TOL);
  localparam logic [31:0] LC  = 32'(LOCK_CNT);
  localparam logic [31:0] TO  = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    LOCK
  } state_t;

  state_t state_q, state_d;

  logic        s1, s2, s3;
  logic        rise;
  logic [31:0] cnt;
  logic [31:0] diff;
  logic [31:0] match, match_d;
  logic        in_tol;
  logic        close;
  logic        tout;
  logic        err_inc;

  assign rise = s2 & ~s3;

  always_comb begin
    diff    = (cnt >= EXP) ? (cnt - EXP) : (EXP - cnt);
    in_tol  = (diff <= TLV);
    state_d = state_q;
    match_d = match;
    close   = 1'b0;
    tout    = 1'b0;
    err_inc = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (rise) state_d = MEAS;
      end
      (state_q == MEAS),
      (state_q == LOCK): begin
        if (rise) begin
          close = 1'b1;
          if (in_tol) begin
            match_d = (match >= LC) ? LC : match + 32'd1;
            if (match_d >= LC) state_d = LOCK;
          end else begin
            match_d = '0;
            err_inc = 1'b1;
            state_d = MEAS;
          end
        end else if (cnt == TO) begin
          tout    = 1'b1;
          err_inc = 1'b1;
          match_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK_IN or negedge clr) begin
    if (!clr) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      match        <= '0;
      PERIOD       <= '0;
      period_valid <= 1'b0;
      LOCKED       <= 1'b0;
      TIMEOUT_FLAG <= 1'b0;
      ERR_CNT      <= '0;
    end else begin
      s1           <= SLOW_IN;
      s2           <= s1;
      s3           <= s2;
      match        <= match_d;
      period_valid <= close;
      LOCKED       <= (state_d == LOCK);
      if (rise)           cnt <= 32'd1;
      else if (cnt != TO) cnt <= cnt + 32'd1;
      if (close) PERIOD <= cnt;
      // flag clears only on the first rise that restarts measurement
      if (tout)
        TIMEOUT_FLAG <= 1'b1;
      else if (rise && state_q == IDLE)
        TIMEOUT_FLAG <= 1'b0;
      if (err_inc && ERR_CNT != 8'hff)
        ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_clkmon.sv
// tb_clkmon: directed SLOW_IN periods; expected
// results queued at stimulus, checked by a monitor.
module tb_clkmon;

  logic        CLK_IN = 1'b0;
  logic        clr = 1'b0;
  logic        SLOW_IN = 1'b0;
  logic [31:0] PERIOD;
  logic        period_valid;
  logic        LOCKED;
  logic        TIMEOUT_FLAG;
  logic [7:0]  ERR_CNT;

  clkmon dut (
    .CLK_IN(CLK_IN),
    .clr(clr),
    .SLOW_IN(SLOW_IN),
    .PERIOD(PERIOD),
    .period_valid(period_valid),
    .LOCKED(LOCKED),
    .TIMEOUT_FLAG(TIMEOUT_FLAG),
    .ERR_CNT(ERR_CNT)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    int unsigned p;
    logic        lk;
    int unsigned ec;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int match_m = 0;
  int err_m = 0;
  bit armed = 1'b0;
  bit jit = 1'b0;
  int prev_len = 0;
  int last_rise = 0;

  always @(posedge CLK_IN) cyc++;

  task automatic chk(string n, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, req);
    end
  endtask

  task automatic model_close(int p);
    exp_t e;
    if (p >= 198 && p <= 202) begin
      match_m = (match_m < 4) ? match_m + 1 : 4;
    end else begin
      match_m = 0;
      if (err_m < 255) err_m++;
    end
    e.p  = p;
    e.lk = (match_m == 4);
    e.ec = err_m;
    q.push_back(e);
  endtask

  task automatic model_reset();
    match_m = 0;
    err_m   = 0;
    armed   = 1'b0;
  endtask

  // one SLOW_IN period of p cycles, rise first
  task automatic per(int p);
    @(negedge CLK_IN);
    SLOW_IN   = 1'b1;
    last_rise = cyc + 1;
    if (armed) model_close(prev_len);
    armed    = 1'b1;
    prev_len = p;
    repeat (p / 2) @(negedge CLK_IN);
    SLOW_IN = 1'b0;
    repeat (p - p / 2 - 1) @(negedge CLK_IN);
  endtask

  always @(negedge CLK_IN) begin
    exp_t e;
    if (period_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse PERIOD %0d", PERIOD);
      end else begin
        e = q.pop_front();
        chk("period", PERIOD, e.p);
        chk("locked", LOCKED, e.lk);
        chk("err_cnt", ERR_CNT, e.ec);
        if (jit) begin
          checks++;
          if (PERIOD < 199 || PERIOD > 201) begin
            errors++;
            $display("FAIL jitter_range got %0d want 199..201",
                     PERIOD);
          end
        end
      end
    end
  end

  int jt[10] = '{200, 201, 199, 201, 199,
                 200, 201, 199, 200, 200};

  initial begin
    int tgt;
    #3;
    chk("rst_period", PERIOD, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_tflag", TIMEOUT_FLAG, 0);
    chk("rst_err", ERR_CNT, 0);
    repeat (3) @(negedge CLK_IN);
    clr = 1'b1;

    // nominal lock, then tolerance edges and re-lock
    repeat (5) per(200);
    per(198);
    per(202);
    per(203);
    repeat (5) per(200);

    // loss of slow clock
    tgt = last_rise + 1001;
    while (cyc < tgt) @(negedge CLK_IN);
    chk("pre_to_tflag", TIMEOUT_FLAG, 0);
    chk("pre_to_locked", LOCKED, 1);
    @(negedge CLK_IN);
    match_m = 0;
    err_m++;
    armed = 1'b0;
    chk("to_tflag", TIMEOUT_FLAG, 1);
    chk("to_locked", LOCKED, 0);
    chk("to_period", PERIOD, 200);
    chk("to_err", ERR_CNT, err_m);

    // restart
    per(200);
    chk("restart_tflag", TIMEOUT_FLAG, 0);
    repeat (4) per(200);

    // reset mid-period while locked
    @(negedge CLK_IN);
    SLOW_IN = 1'b1;
    model_close(prev_len);
    repeat (50) @(negedge CLK_IN);
    chk("pre_rst_locked", LOCKED, 1);
    #2 clr = 1'b0;
    #1;
    chk("arst_period", PERIOD, 0);
    chk("arst_pv", period_valid, 0);
    chk("arst_locked", LOCKED, 0);
    chk("arst_tflag", TIMEOUT_FLAG, 0);
    chk("arst_err", ERR_CNT, 0);
    model_reset();
    SLOW_IN = 1'b0;
    repeat (3) @(negedge CLK_IN);
    clr = 1'b1;
    repeat (3) per(200);

    // jittered edges
    jit = 1'b1;
    foreach (jt[i]) per(jt[i]);
    per(200);
    jit = 1'b0;

    // error counter saturation
    @(negedge CLK_IN);
    clr = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK_IN);
    clr = 1'b1;
    repeat (301) per(150);
    repeat (5) @(negedge CLK_IN);
    chk("sat_err", ERR_CNT, 255);
    chk("sat_locked", LOCKED, 0);
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
